// File: rtl/tick_pkg.sv
// Shared constants and helpers for the tick_chain prescaler family.
package tick_pkg;

  localparam int CLK_HZ           = 500_000_000;
  localparam int BASE_PERIOD_1KHZ = CLK_HZ / 1000;
  localparam int DECADE_RATIO     = 10;

  // Ceiling log2 for tools that lack $clog2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_stage.sv
// One mod-RATIO divider stage: advances on hit_in, passes hit_out on its wrap.
module tick_stage
  import tick_pkg::*;
#(
  parameter int RATIO = DECADE_RATIO,
  parameter int CW    = clog2(RATIO)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          hit_in,
  output logic          hit_out,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CW'(RATIO - 1));
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (hit_in) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_out = hit_in & wrap;
  assign cnt     = cnt_q;

endmodule

// File: rtl/tick_chain.sv
// Base prescaler plus a cascade of mod-RATIO stages producing registered
// tick pulses and toggle-on-tick square waves for every channel.
module tick_chain
  import tick_pkg::*;
#(
  parameter int BASE_PERIOD = 500_000,
  parameter int CHANNELS    = 4,
  parameter int RATIO       = 10,
  parameter int CNT_W       = clog2(BASE_PERIOD + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic                period_load,
  input  logic [CNT_W-1:0]    period_in,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] wave
);

  localparam int SCW = clog2(RATIO);

  if (BASE_PERIOD < 1 || CHANNELS < 1 || RATIO < 2) begin : g_param_err
    $error("tick_chain: need BASE_PERIOD>=1, CHANNELS>=1, RATIO>=2");
  end

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] wave_q, wave_d;
  logic [CHANNELS-1:0] hit;
  logic                hit0;

  // A load or clear restarts the base count, so no hit may escape on that edge.
  assign hit0   = en & ~clr & ~period_load & (cnt_q == period_q - 1'b1);
  assign hit[0] = hit0;

  for (genvar k = 1; k < CHANNELS; k++) begin : g_stage
    logic           h_in;
    logic           h_out;
    logic [SCW-1:0] cnt;

    if (k == 1) begin : g_first
      assign h_in = hit0;
    end else begin : g_next
      assign h_in = g_stage[k-1].h_out;
    end

    tick_stage #(
      .RATIO (RATIO),
      .CW    (SCW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .hit_in  (h_in),
      .hit_out (h_out),
      .cnt     (cnt)
    );

    assign hit[k] = h_out;

    always_comb assert ({1'b0, cnt} < (SCW + 1)'(RATIO));
  end

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (period_load) begin
      period_d = (period_in == '0) ? CNT_W'(1) : period_in;
    end
    if (clr || period_load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = hit0 ? '0 : cnt_q + 1'b1;
    end
    tick_d = clr ? '0 : hit;
    wave_d = clr ? '0 : (wave_q ^ hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= CNT_W'(BASE_PERIOD);
      tick_q   <= '0;
      wave_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      wave_q   <= wave_d;
    end
  end

  assign tick = tick_q;
  assign wave = wave_q;

endmodule

// File: tb/tb_tick_chain.sv
// Directed bench for tick_chain: small instance (4/3/3) plus a default-parameter
// instance exercised through counter preloads.
module tb_tick_chain;

  localparam int BP  = 4;
  localparam int R   = 3;
  localparam int CH  = 3;
  localparam int CW  = 3;
  localparam int DBP = 500_000;
  localparam int DCW = 19;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, clr, period_load;
  logic [CW-1:0] period_in;
  logic [CH-1:0] tick, wave;

  logic           en_d, clr_d, load_d;
  logic [DCW-1:0] period_in_d;
  logic [3:0]     tick_d, wave_d;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  tick_chain #(.BASE_PERIOD(BP), .CHANNELS(CH), .RATIO(R)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .period_load (period_load),
    .period_in   (period_in),
    .tick        (tick),
    .wave        (wave)
  );

  tick_chain dut_d (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_d),
    .clr         (clr_d),
    .period_load (load_d),
    .period_in   (period_in_d),
    .tick        (tick_d),
    .wave        (wave_d)
  );

  // Expected outputs after e enabled, uncleared edges at period BP.
  function automatic logic [CH-1:0] exp_tick(input int e, input bit fired);
    int p;
    logic [CH-1:0] t;
    p = BP;
    t = '0;
    for (int k = 0; k < CH; k++) begin
      t[k] = fired && (e > 0) && (e % p == 0);
      p = p * R;
    end
    return t;
  endfunction

  function automatic logic [CH-1:0] exp_wave(input int e);
    int p;
    logic [CH-1:0] w;
    p = BP;
    w = '0;
    for (int k = 0; k < CH; k++) begin
      w[k] = ((e / p) % 2) == 1;
      p = p * R;
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en = 1'b0; clr = 1'b0; period_load = 1'b0; period_in = '0;
    en_d = 1'b0; clr_d = 1'b0; load_d = 1'b0; period_in_d = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0; clr = 1'b0; period_load = 1'b0; period_in = '0;
    en_d = 1'b0; clr_d = 1'b0; load_d = 1'b0; period_in_d = '0;
    #1;
    checks++;
    if ({tick, wave} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got tick=%b wave=%b, want 000/000", tick, wave);
    end
    checks++;
    if ({tick_d, wave_d} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs_default: got tick=%b wave=%b, want 0", tick_d, wave_d);
    end
  endtask

  task automatic test_free_run();
    apply_reset();
    en = 1'b1;
    for (int c = 1; c <= 72; c++) begin
      step();
      checks++;
      if (tick !== exp_tick(c, 1'b1) || wave !== exp_wave(c)) begin
        errors++;
        $display("FAIL free_run c=%0d: got tick=%b wave=%b, want tick=%b wave=%b",
                 c, tick, wave, exp_tick(c, 1'b1), exp_wave(c));
      end
    end
  endtask

  task automatic test_pause();
    int e;
    bit run;
    apply_reset();
    e = 0;
    for (int c = 1; c <= 24; c++) begin
      run = !(c >= 7 && c <= 11);
      en = run;
      step();
      if (run) e++;
      checks++;
      if (tick !== exp_tick(e, run) || wave !== exp_wave(e)) begin
        errors++;
        $display("FAIL pause c=%0d: got tick=%b wave=%b, want tick=%b wave=%b",
                 c, tick, wave, exp_tick(e, run), exp_wave(e));
      end
    end
    en = 1'b1;
  endtask

  task automatic test_clr();
    int e;
    apply_reset();
    en = 1'b1;
    e = 0;
    for (int c = 1; c <= 30; c++) begin
      clr = (c == 11);
      step();
      e = (c == 11) ? 0 : e + 1;
      checks++;
      if (tick !== exp_tick(e, c != 11) || wave !== exp_wave(e)) begin
        errors++;
        $display("FAIL clr c=%0d: got tick=%b wave=%b, want tick=%b wave=%b",
                 c, tick, wave, exp_tick(e, c != 11), exp_wave(e));
      end
    end
    clr = 1'b0;
  endtask

  // Loads at edges 5 (2), 12 (0), 15 (0, lands on a would-be hit) and clr+load at 21 (3).
  task automatic test_period_load();
    logic [CH-1:0] et [24];
    logic [CH-1:0] ew [24];
    et = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000,
           3'b011, 3'b000, 3'b001, 3'b000, 3'b001, 3'b011, 3'b000, 3'b001,
           3'b001, 3'b111, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
    ew = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
           3'b011, 3'b011, 3'b010, 3'b010, 3'b011, 3'b000, 3'b000, 3'b001,
           3'b000, 3'b111, 3'b110, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001};
    apply_reset();
    en = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      period_load = (c == 5 || c == 12 || c == 15 || c == 21);
      clr         = (c == 21);
      period_in   = (c == 5) ? 3'd2 : (c == 21) ? 3'd3 : 3'd0;
      step();
      checks++;
      if (tick !== et[c-1] || wave !== ew[c-1]) begin
        errors++;
        $display("FAIL period_load c=%0d: got tick=%b wave=%b, want tick=%b wave=%b",
                 c, tick, wave, et[c-1], ew[c-1]);
      end
    end
    period_load = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    en = 1'b1;
    repeat (14) step();
    checks++;
    if (tick !== 3'b000 || wave !== 3'b011) begin
      errors++;
      $display("FAIL async_pre c=14: got tick=%b wave=%b, want 000/011", tick, wave);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tick !== 3'b000 || wave !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got tick=%b wave=%b, want 000/000", tick, wave);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      checks++;
      if (tick !== exp_tick(c, 1'b1) || wave !== exp_wave(c)) begin
        errors++;
        $display("FAIL async_restart c=%0d: got tick=%b wave=%b, want tick=%b wave=%b",
                 c, tick, wave, exp_tick(c, 1'b1), exp_wave(c));
      end
    end
  endtask

  task automatic test_default_params();
    int n;
    apply_reset();
    force dut_d.cnt_d = DCW'(DBP - 5);
    force dut_d.g_stage[1].u_stage.cnt_d = 4'd9;
    force dut_d.g_stage[2].u_stage.cnt_d = 4'd9;
    force dut_d.g_stage[3].u_stage.cnt_d = 4'd9;
    @(posedge clk);
    #1;
    release dut_d.cnt_d;
    release dut_d.g_stage[1].u_stage.cnt_d;
    release dut_d.g_stage[2].u_stage.cnt_d;
    release dut_d.g_stage[3].u_stage.cnt_d;
    @(negedge clk);
    en_d = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++;
      if (tick_d !== ((c == 5) ? 4'b1111 : 4'b0000) || wave_d !== ((c == 5) ? 4'b1111 : 4'b0000)) begin
        errors++;
        $display("FAIL default_all_wrap c=%0d: got tick=%b wave=%b", c, tick_d, wave_d);
      end
    end
    n = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (tick_d != 4'b0) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL default_spacing: got %0d ticks in 1000 cycles, want 0", n);
    end
    en_d = 1'b0;
    force dut_d.cnt_d = DCW'(DBP - 5);
    @(posedge clk);
    #1;
    release dut_d.cnt_d;
    @(negedge clk);
    en_d = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++;
      if (tick_d !== ((c == 5) ? 4'b0001 : 4'b0000) || wave_d !== ((c == 5) ? 4'b1110 : 4'b1111)) begin
        errors++;
        $display("FAIL default_base_only c=%0d: got tick=%b wave=%b", c, tick_d, wave_d);
      end
    end
    en_d = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_pause();
    test_clr();
    test_period_load();
    test_async_reset();
    test_default_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
